// File: rtl/mac_stream_unit.sv
// mac_stream_unit: streaming FP16 multiply-accumulate engine.
//   P = P0 + sum(a[i] * b[i]) over a runtime vector length. The block takes one
//   operand pair per valid/ready handshake. P0 is +0 when clear_acc is set with
//   start, otherwise it is the current P.
//
// Ports (mac_stream_unit):
//   clk, reset_n      clock and asynchronous active-low reset
//   start, clear_acc  job request and accumulate-or-clear mode (sampled in IDLE)
//   len               element count, clamped to MAX_LEN
//   abort             cancels a running job; P and count keep committed values
//   in_valid/in_ready operand handshake; a, b are FP16 operands
//   P                 FP16 accumulator, held between jobs
//   busy, done, count job status; done is a one-cycle completion pulse
//
// Arithmetic comes from one floating_point_multiplayer and one
// floating_point_adder. Both are defined in this file. They share a common
// handshake: hold en until ready, and clear them with the active-high rst.
// Their FP16 behaviour: round-to-nearest-even, subnormal inputs and outputs
// flushed to signed zero, overflow to infinity, canonical NaN 0x7E00.

package mac_stream_fp16_pkg;

  function automatic logic fp16_is_nan(input logic [15:0] v);
    return (&v[14:10]) && (|v[9:0]);
  endfunction

  // norm[13] is the hidden bit, norm[12:3] the fraction, norm[2] the guard bit
  // and norm[1:0] the sticky bits. exp_in is the biased exponent before rounding.
  function automatic logic [15:0] fp16_round_pack(input logic              sign,
                                                  input logic signed [7:0] exp_in,
                                                  input logic [13:0]       norm);
    logic [11:0]       rnd;
    logic [10:0]       mant;
    logic signed [7:0] e;
    rnd  = {1'b0, norm[13:3]} + 12'(norm[2] & (norm[1] | norm[0] | norm[3]));
    e    = exp_in;
    mant = rnd[10:0];
    if (rnd[11]) begin
      mant = rnd[11:1];
      e    = e + 8'sd1;
    end
    if (e >= 8'sd31) return {sign, 5'h1F, 10'h000};
    if (e <= 8'sd0)  return {sign, 15'h0000};
    return {sign, e[4:0], mant[9:0]};
  endfunction

endpackage

module floating_point_multiplayer
  import mac_stream_fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out,
  output logic        ready
);
  logic              sign;
  logic [21:0]       prod;
  logic signed [7:0] e;
  logic [13:0]       norm;
  logic [15:0]       res;
  logic [15:0]       out_q;
  logic              ready_q;

  // NOTE: every variable written in always_comb is assigned on every path
  // (defaults first where branches diverge), so no latch can be inferred.
  always_comb begin
    sign = a[15] ^ b[15];
    prod = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e    = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
    if (prod[21]) begin
      norm = {prod[21:11], prod[10], |prod[9:0], 1'b0};
      e    = e + 8'sd1;
    end else begin
      norm = {prod[20:10], prod[9], |prod[8:0], 1'b0};
    end
    res = fp16_round_pack(sign, e, norm);
    if (fp16_is_nan(a) || fp16_is_nan(b)) begin
      res = 16'h7E00;
    end else if ((&a[14:10]) || (&b[14:10])) begin
      res = (a[14:10] == 5'd0 || b[14:10] == 5'd0) ? 16'h7E00 : {sign, 5'h1F, 10'h000};
    end else if (a[14:10] == 5'd0 || b[14:10] == 5'd0) begin
      res = {sign, 15'h0000};
    end
  end

  // NOTE: rst is synchronous. The parent decodes it from FSM state, so an
  // asynchronous use would let decode glitches clear the unit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      out_q   <= '0;
    end else if (en && !ready_q) begin
      ready_q <= 1'b1;
      out_q   <= res;
    end
  end

  assign out   = out_q;
  assign ready = ready_q;
endmodule

module floating_point_adder
  import mac_stream_fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out,
  output logic        ready
);
  logic [15:0]       x, y;
  logic [4:0]        ex, ey, d;
  logic [13:0]       mx, my, my_full, norm;
  logic [14:0]       acc;
  logic [3:0]        lz;
  logic signed [7:0] e;
  logic [15:0]       res;
  logic [15:0]       out_q;
  logic              ready_q;

  always_comb begin
    // x is always the operand of larger magnitude, so d below is never negative.
    x = a;
    y = b;
    if (a[14:0] < b[14:0]) begin
      x = b;
      y = a;
    end
    ex      = x[14:10];
    ey      = y[14:10];
    d       = ex - ey;
    mx      = {1'b1, x[9:0], 3'b000};
    my_full = {1'b1, y[9:0], 3'b000};
    lz      = '0;
    norm    = '0;
    e       = $signed({3'b000, ex});
    // Bits shifted out of y collapse into the sticky LSB.
    if (d >= 5'd14) my = 14'd1;
    else            my = (my_full >> d) | {13'd0, |(my_full & ~(14'h3FFF << d))};
    if (x[15] == y[15]) begin
      acc = {1'b0, mx} + {1'b0, my};
      if (acc[14]) begin
        norm = {acc[14:2], acc[1] | acc[0]};
        e    = e + 8'sd1;
      end else begin
        norm = acc[13:0];
      end
    end else begin
      acc = {1'b0, mx} - {1'b0, my};
      for (int i = 0; i < 14; i++) begin
        if (acc[i]) lz = 4'(13 - i);
      end
      norm = acc[13:0] << lz;
      e    = e - $signed({4'b0000, lz});
    end
    res = fp16_round_pack(x[15], e, norm);
    if (fp16_is_nan(a) || fp16_is_nan(b)) begin
      res = 16'h7E00;
    end else if (&ex) begin
      res = ((&ey) && (x[15] != y[15])) ? 16'h7E00 : x;
    end else if (ex == 5'd0) begin
      res = {x[15] & y[15], 15'h0000};
    end else if (ey == 5'd0) begin
      res = x;
    end else if (acc == 15'd0) begin
      res = 16'h0000;  // exact cancellation yields +0
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      out_q   <= '0;
    end else if (en && !ready_q) begin
      ready_q <= 1'b1;
      out_q   <= res;
    end
  end

  assign out   = out_q;
  assign ready = ready_q;
endmodule

module mac_stream_unit #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             clear_acc,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  output logic [15:0]      P,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] count
);
  typedef enum logic [2:0] {IDLE, FETCH, MUL, ADD, FLUSH, DONE} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, count_q, count_d, len_clamped, count_inc;
  logic [15:0]      p_q, p_d, op_a_q, op_a_d, op_b_q, op_b_d, prod_q, prod_d;
  logic             to_idle_q, to_idle_d;  // current FLUSH ends the job (abort)

  logic             sub_rst, mult_en, add_en, mult_ready, add_ready;
  logic [15:0]      mult_out, add_out;

  assign len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  assign count_inc   = count_q + LEN_W'(1);

  // FLUSH and DONE clear both units, so a ready flag never survives into the
  // next element.
  assign sub_rst = ~reset_n || (state_q == FLUSH) || (state_q == DONE);
  assign mult_en = (state_q == MUL);
  assign add_en  = (state_q == ADD);

  floating_point_multiplayer u_mul (
    .clk   (clk),
    .rst   (sub_rst),
    .en    (mult_en),
    .a     (op_a_q),
    .b     (op_b_q),
    .out   (mult_out),
    .ready (mult_ready)
  );

  floating_point_adder u_add (
    .clk   (clk),
    .rst   (sub_rst),
    .en    (add_en),
    .a     (prod_q),
    .b     (p_q),
    .out   (add_out),
    .ready (add_ready)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    p_d       = p_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    prod_d    = prod_q;
    to_idle_d = to_idle_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = len_clamped;
          count_d   = '0;
          to_idle_d = 1'b0;
          if (clear_acc) p_d = 16'h0000;
          state_d = (len_clamped != '0) ? FETCH : DONE;
        end
      end
      FETCH: begin
        if (abort) begin
          to_idle_d = 1'b1;
          state_d   = FLUSH;
        end else if (in_valid) begin
          op_a_d  = a;
          op_b_d  = b;
          state_d = MUL;
        end
      end
      MUL: begin
        if (abort) begin
          to_idle_d = 1'b1;
          state_d   = FLUSH;
        end else if (mult_ready) begin
          prod_d  = mult_out;
          state_d = ADD;
        end
      end
      ADD: begin
        // A commit on the abort cycle still lands; the abort then ends the job.
        if (add_ready) begin
          p_d     = add_out;
          count_d = count_inc;
          state_d = (count_inc == len_q) ? DONE : FLUSH;
        end
        if (abort) begin
          to_idle_d = 1'b1;
          state_d   = FLUSH;
        end
      end
      FLUSH: begin
        state_d   = (to_idle_q || abort) ? IDLE : FETCH;
        to_idle_d = 1'b0;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      count_q   <= '0;
      p_q       <= 16'h0000;
      op_a_q    <= '0;
      op_b_q    <= '0;
      prod_q    <= '0;
      to_idle_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      count_q   <= count_d;
      p_q       <= p_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      prod_q    <= prod_d;
      to_idle_q <= to_idle_d;
    end
  end

  assign in_ready = (state_q == FETCH);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign P        = p_q;
  assign count    = count_q;
endmodule

// File: tb/tb_mac_stream_unit.sv
// Testbench for mac_stream_unit. Directed and random jobs are checked against
// an arithmetic reference model. Operands are nonzero multiples of 0.5 with
// magnitude at most 4. The model keeps the accumulator as an exact integer
// count of quarters, so any correctly rounded FP16 datapath must match it
// bit for bit.
module tb_mac_stream_unit;
  localparam int MAX_LEN = 64;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0, clear_acc = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [15:0]      a = '0, b = '0;
  logic             in_ready, busy, done;
  logic [15:0]      p;
  logic [LEN_W-1:0] count;

  int checks = 0, errors = 0;
  int hs_cnt = 0, done_cnt = 0;
  int model_q = 0;          // reference accumulator, in units of 0.25
  int opa[$], opb[$];       // operand values, in units of 0.25

  mac_stream_unit #(.MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .clear_acc (clear_acc),
    .len       (len),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .P         (p),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_valid && in_ready) hs_cnt++;
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Exact FP16 encoding of q/4 (the value must be representable).
  function automatic logic [15:0] q_to_fp16(input int q);
    int          m, e;
    logic [31:0] mant;
    logic [4:0]  bexp;
    if (q == 0) return 16'h0000;
    m = (q < 0) ? -q : q;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    mant = 32'(m) << (10 - e);
    bexp = 5'(e + 13);
    return {q < 0, bexp, mant[9:0]};
  endfunction

  function automatic int rand_operand();
    int k;
    k = int'($urandom_range(8, 1)) * 2;
    return ($urandom_range(1, 0) == 1) ? -k : k;
  endfunction

  // Waits for in_ready, idles for `stall` cycles, then transfers one pair.
  task automatic feed_pair(input int qa, input int qb, input int stall, input string tag);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, " in_ready timeout"}, 32'(t < 100), 32'd1);
    for (int s = 0; s < stall; s++) begin
      check({tag, " in_ready held while stalled"}, 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b1;
    a = q_to_fp16(qa);
    b = q_to_fp16(qb);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    check({tag, " in_ready drops after handshake"}, 32'(in_ready), 32'd0);
    model_q += (qa * qb) / 4;
  endtask

  task automatic wait_done(input string tag, input int n);
    int t;
    t = 0;
    while (!done && t < 400) begin
      @(negedge clk);
      t++;
    end
    check({tag, " done timeout"}, 32'(t < 400), 32'd1);
    check({tag, " P"}, 32'(p), 32'(q_to_fp16(model_q)));
    check({tag, " count"}, 32'(count), 32'(n));
    @(negedge clk);
    check({tag, " done one cycle"}, 32'(done), 32'd0);
    check({tag, " busy falls after done"}, 32'(busy), 32'd0);
    check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
    check({tag, " handshakes"}, 32'(hs_cnt), 32'(n));
  endtask

  // stall < 0 selects a random 0..2 cycle stall per element.
  task automatic run_job(input bit clr, input int len_in, input int stall, input string tag);
    int n;
    n = (len_in > MAX_LEN) ? MAX_LEN : len_in;
    @(negedge clk);
    hs_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    clear_acc = clr;
    len = LEN_W'(len_in);
    if (clr) model_q = 0;
    @(negedge clk);
    start = 1'b0;
    clear_acc = 1'b0;
    check({tag, " busy after start"}, 32'(busy), 32'd1);
    if (n == 0) check({tag, " done right after start"}, 32'(done), 32'd1);
    else        check({tag, " in_ready after start"}, 32'(in_ready), 32'd1);
    for (int i = 0; i < n; i++)
      feed_pair(opa[i], opb[i], (stall < 0) ? int'($urandom_range(2, 0)) : stall, tag);
    wait_done(tag, n);
  endtask

  initial begin
    int t, exp_p;
    repeat (3) @(negedge clk);
    check("reset P", 32'(p), 32'h0000);
    check("reset done", 32'(done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset count", 32'(count), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic dot product: 1*2 + 2*2 + 3*2 = 12.0
    opa = '{4, 8, 12};
    opb = '{8, 8, 8};
    run_job(1'b1, 3, 0, "basic");
    check("basic P literal", 32'(p), 32'h4A00);

    // Accumulate: 12 + 0.5*2 = 13.0
    opa = '{2};
    opb = '{8};
    run_job(1'b0, 1, 0, "accumulate");
    check("accumulate P literal", 32'(p), 32'h4A80);

    // Backpressure: five idle cycles before every pair
    opa = '{4, 8, 12};
    opb = '{8, 8, 8};
    run_job(1'b1, 3, 5, "backpressure");
    check("backpressure P literal", 32'(p), 32'h4A00);

    // Zero length keeps or clears P without any handshake
    run_job(1'b0, 0, 0, "len0 keep");
    check("len0 keep P literal", 32'(p), 32'h4A00);
    run_job(1'b1, 0, 0, "len0 clear");

    // Length clamp: 64 products of 1*1
    opa.delete();
    opb.delete();
    for (int i = 0; i < MAX_LEN; i++) begin
      opa.push_back(4);
      opb.push_back(4);
    end
    run_job(1'b1, MAX_LEN + 5, 0, "clamp");
    check("clamp P literal", 32'(p), 32'h5400);

    // Abort during MUL of element 2
    @(negedge clk);
    hs_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    clear_acc = 1'b1;
    len = LEN_W'(3);
    model_q = 0;
    @(negedge clk);
    start = 1'b0;
    clear_acc = 1'b0;
    feed_pair(6, -8, 0, "abort");
    exp_p = model_q;
    feed_pair(4, 4, 0, "abort");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    model_q = exp_p;
    check("abort busy timeout", 32'(t < 50), 32'd1);
    check("abort count", 32'(count), 32'd1);
    check("abort P", 32'(p), 32'(q_to_fp16(exp_p)));
    repeat (2) @(negedge clk);
    check("abort no done", 32'(done_cnt), 32'd0);
    opa = '{-4, 16};
    opb = '{2, 6};
    run_job(1'b0, 2, 1, "after abort");

    // Reset during ADD: two MUL cycles after the handshake, then ADD
    @(negedge clk);
    start = 1'b1;
    len = LEN_W'(2);
    @(negedge clk);
    start = 1'b0;
    feed_pair(8, 8, 0, "reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midjob reset P", 32'(p), 32'h0000);
    check("midjob reset done", 32'(done), 32'd0);
    check("midjob reset busy", 32'(busy), 32'd0);
    check("midjob reset in_ready", 32'(in_ready), 32'd0);
    check("midjob reset count", 32'(count), 32'd0);
    model_q = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Start held high and re-pulsed while busy: exactly one job runs
    @(negedge clk);
    hs_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    clear_acc = 1'b1;
    len = LEN_W'(2);
    model_q = 0;
    @(negedge clk);
    feed_pair(4, 2, 0, "misuse");
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    feed_pair(-6, 8, 0, "misuse");
    t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    clear_acc = 1'b0;
    check("misuse done timeout", 32'(t < 100), 32'd1);
    check("misuse P", 32'(p), 32'(q_to_fp16(model_q)));
    check("misuse P literal", 32'(p), 32'hC100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("misuse stays idle", 32'(busy), 32'd0);
    end
    check("misuse handshakes", 32'(hs_cnt), 32'd2);
    check("misuse done pulses", 32'(done_cnt), 32'd1);

    // Random jobs: random lengths, operands, modes and stalls
    for (int j = 0; j < 10; j++) begin
      int  n;
      bit  clr;
      n = int'($urandom_range(6, 0));
      clr = ($urandom_range(1, 0) == 1) || (model_q > 1200) || (model_q < -1200);
      opa.delete();
      opb.delete();
      for (int i = 0; i < n; i++) begin
        opa.push_back(rand_operand());
        opb.push_back(rand_operand());
      end
      run_job(clr, n, -1, $sformatf("random job %0d", j));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
